ifu_fetch_ctrl: RTL
===================

// Module: ifu_fetch_ctrl
// PURPOSE
//   Instruction-fetch front end that consumes the next-PC produced by the next-PC logic.
//   Holds the architectural PC, issues word fetches to instruction memory over a
//   req/ready interface, and buffers one fetched instruction for decode (valid/ready).
//   Taken branch/jump/jr redirects are applied here and squash in-flight or buffered work.
// PARAMETERS
//   RESET_PC    32'h0000_3000  PC loaded on reset
//   IMEM_BASE   32'h0000_3000  lowest legal fetch address (range check only)
//   IMEM_WORDS  4096           legal words from IMEM_BASE (range check only)
// PORTS
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   redirect     in   1   one-cycle pulse: taken branch/jump/jr
//   redirect_pc  in   32  target PC when redirect=1
//   imem_req     out  1   fetch request
//   imem_addr    out  32  word address of request (= pc)
//   imem_ready   in   1   memory response; imem_rdata valid this cycle
//   imem_rdata   in   32  fetched instruction
//   instr_valid  out  1   instr/instr_pc/pc4 valid
//   instr_ready  in   1   decode accepts instr this cycle
//   instr        out  32  buffered instruction
//   instr_pc     out  32  PC of buffered instruction
//   pc4          out  32  instr_pc + 4
//   fetch_exc    out  1   fetch address fault (FETCH_ADDR_CHECK_EN only; else tied 0)
// BEHAVIOUR
//   - Reset (async): pc=RESET_PC, state=FETCH, instr_valid=0, instr=0, instr_pc=0,
//     fetch_exc=0. imem_req=0 while reset high; first request in cycle after release.
//   - States: FETCH (req pending, buffer empty), OUT (buffer full).
//   - imem_req = (state==FETCH) | (state==OUT & instr_ready); imem_addr = pc.
//   - Memory samples imem_addr in the imem_ready cycle; response is combinational with
//     imem_ready. A request abandoned on redirect needs no cancel; memory tolerates addr change.
//   - FETCH & imem_ready: buffer<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, ->OUT.
//   - OUT & instr_ready & imem_ready: buffer reloaded same edge (back-to-back, 1 instr/cycle).
//   - OUT & instr_ready & !imem_ready: instr_valid<=0, ->FETCH (req stays high).
//   - OUT & !instr_ready: hold all outputs stable, no request.
//   - redirect has priority over every other event: pc<=redirect_pc, instr_valid<=0,
//     state<=FETCH; response arriving in the redirect cycle is discarded; instr_ready in
//     same cycle is ignored (buffered instr squashed, not counted as accepted).
//   - PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
//   - pc4 = instr_pc + 4 (combinational, same wrap rule).
//   - Reset asserted mid-fetch: all state cleared immediately; stale response ignored.
// CONFIGURATION
//   FETCH_ADDR_CHECK_EN defined: before requesting, pc checked; misaligned (pc[1:0]!=0)
//     or outside [IMEM_BASE, IMEM_BASE+4*IMEM_WORDS) -> no imem_req; buffer loads
//     instr=32'h0 (nop), instr_pc=pc, fetch_exc=1 with instr_valid, ->OUT; pc not
//     advanced (stays at faulting pc until redirect/reset). fetch_exc clears with buffer.
//   Not defined: no check; imem_addr = {pc[31:2],2'b00}; fetch_exc tied 0.
// TESTING
//   1 reset high 3 cycles, release, imem_ready=1, instr_ready=1 -> imem_addr 0x3000,
//     then instr_valid with instr_pc 0x3000, pc4 0x3004, next cycle instr_pc 0x3004.
//   2 instr_ready=0 for 4 cycles while instr_valid -> instr/instr_pc stable, imem_req=0;
//     instr_ready=1 -> next instr_pc = previous+4, no word skipped or duplicated.
//   3 imem_ready delayed 3 cycles, redirect to 0x3100 in cycle 2 -> late response dropped,
//     next instr_valid carries instr_pc 0x3100.
//   4 redirect to 0x3040 same cycle as imem_ready and instr_ready -> neither response nor
//     buffered instr delivered; next delivered instr_pc 0x3040.
//   5 redirect to 0xFFFF_FFFC (macro off) -> instr_pc 0xFFFF_FFFC, pc4 0x0, next fetch 0x0.
//   6 macro on, redirect to 0x3002 -> no imem_req, instr_valid=1, instr=0, fetch_exc=1,
//     instr_pc 0x3002; redirect 0x3000 clears fetch_exc and resumes normal fetch.

Source files
------------

// File: rtl/ifu_fetch_ctrl_if.sv
// ifu_fetch_ctrl_if: redirect, instruction-memory and decode handshake bundle for the fetch front end.
// master = fetch controller, slave = surrounding pipeline/memory side.
interface ifu_fetch_ctrl_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc4;
    logic        fetch_exc;
    modport master (
        input  redirect, redirect_pc, imem_ready, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc4, fetch_exc
    );
    modport slave (
        output redirect, redirect_pc, imem_ready, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc4, fetch_exc
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: holds the PC, fetches words over req/ready and buffers one instruction for decode.
// Optional FETCH_ADDR_CHECK_EN: faulting PCs deliver a nop with fetch_exc instead of requesting.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 4096
) (
    input logic              clk,
    input logic              reset,
    ifu_fetch_ctrl_if.master bus
);
    typedef enum logic {FETCH, OUT} state_e;
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d, exc_q, exc_d;
    logic        want, fault, load;
    function automatic logic addr_fault(input logic [31:0] a);
        logic [32:0] lo, hi;
        lo = {1'b0, IMEM_BASE};
        hi = lo + 33'(IMEM_WORDS) * 33'd4;
        return (a[1:0] != 2'b00) || ({1'b0, a} < lo) || ({1'b0, a} >= hi);
    endfunction
`ifdef FETCH_ADDR_CHECK_EN
    assign fault         = addr_fault(pc_q);
    assign bus.imem_addr = pc_q;
`else
    assign fault         = 1'b0;
    assign bus.imem_addr = {pc_q[31:2], 2'b00};
`endif
    // A slot is wanted when the buffer is empty or is being drained this cycle.
    assign want         = (state_q == FETCH) || ((state_q == OUT) && bus.instr_ready);
    assign bus.imem_req = want && !fault && !reset;
    assign load         = want && (bus.imem_ready || fault);
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        exc_d      = exc_q;
        if (bus.redirect) begin
            pc_d    = bus.redirect_pc;
            valid_d = 1'b0;
            exc_d   = 1'b0;
            state_d = FETCH;
        end else if (load) begin
            instr_d    = fault ? 32'h0 : bus.imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = fault ? pc_q : pc_q + 32'd4;
            valid_d    = 1'b1;
            exc_d      = fault;
            state_d    = OUT;
        end else if ((state_q == OUT) && bus.instr_ready) begin
            valid_d = 1'b0;
            exc_d   = 1'b0;
            state_d = FETCH;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            valid_q    <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            exc_q      <= exc_d;
        end
    end
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.pc4         = instr_pc_q + 32'd4;
    assign bus.fetch_exc   = exc_q;
endmodule
